pci_arbiter: RTL

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_pkg.sv | 20 ++
 rtl/pci_rr_picker.sv | 31 +++
 rtl/pci_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus arbiter: FSM encoding, parameter
// defaults and the BUS_OWNER width helper.
package pci_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int GNT_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    BUSY       = 2'd2,
    TURNAROUND = 2'd3
  } pci_state_e;

  // Width of an index into N requesters; never narrower than one bit.
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin search: starting at ptr and wrapping, the first
// asserted (active-high) request wins.
module pci_rr_picker
  import pci_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int OW    = owner_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [OW-1:0]    winner,
  output logic             found
);

  // Walk the requesters in priority order from ptr, keep the first hit.
  always_comb begin : pick
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin grant to one of N_REQ masters, revoked when
// the master starts a transaction, drops its request or lets the grant time
// out. One idle turnaround clock always separates two owners.
//
// Handshake: a grant is offered by driving GNT_N[i]=0; the master accepts it
// by driving FRAME=0 while granted. Dropping REQ_N[i] or failing to accept
// within GNT_TIMEOUT clocks withdraws the offer. The bus is free again only
// once FRAME=1 and IRDY=1 are seen on the same edge.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int GNT_TIMEOUT = GNT_TIMEOUT_DEF,
  localparam int OW          = owner_width(N_REQ),
  localparam int TW          = $clog2(GNT_TIMEOUT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] REQ_N,
  input  logic             FRAME,
  input  logic             IRDY,
  output logic [N_REQ-1:0] GNT_N,
  output logic [OW-1:0]    BUS_OWNER,
  output logic             OWNER_VALID,
  output pci_state_e       state_dbg,
  output logic [OW-1:0]    ptr_dbg
);

  pci_state_e       state_q, state_d;
  logic [OW-1:0]    ptr_q;
  logic [TW-1:0]    timer_q;
  logic [OW-1:0]    winner;
  logic             found;
  logic             bus_idle;
  logic             grant;
  logic             owner_released;
  logic             timed_out;
  logic [N_REQ-1:0] gnt_n_d;
  logic [OW-1:0]    owner_d;
  logic             valid_d;

  pci_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (~REQ_N),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  assign bus_idle       = FRAME & IRDY;
  assign grant          = (state_q == IDLE) && bus_idle && found;
  assign owner_released = REQ_N[BUS_OWNER];
  assign timed_out      = (timer_q == TW'(GNT_TIMEOUT - 1));

  assign state_dbg = state_q;
  assign ptr_dbg   = ptr_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; FRAME accepted by the owner beats release and timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (grant) state_d = GRANTED;
      GRANTED: begin
        if (!FRAME)                          state_d = BUSY;
        else if (owner_released || timed_out) state_d = TURNAROUND;
      end
      BUSY:       if (bus_idle) state_d = TURNAROUND;
      TURNAROUND: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    owner_d = grant ? winner : BUS_OWNER;
    valid_d = (state_d == GRANTED) || (state_d == BUSY);
    gnt_n_d = '1;
    if (state_d == GRANTED) gnt_n_d[owner_d] = 1'b0;
  end

  // Output registers, so no output glitches between edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      GNT_N       <= '1;
      BUS_OWNER   <= '0;
      OWNER_VALID <= 1'b0;
    end else begin
      GNT_N       <= gnt_n_d;
      BUS_OWNER   <= owner_d;
      OWNER_VALID <= valid_d;
    end
  end

  // Round-robin pointer moves past the winner only when a grant issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else if (grant)
      ptr_q <= (winner == OW'(N_REQ - 1)) ? '0 : winner + OW'(1);
  end

  // Grant timer: cleared at grant, counts every clock spent in GRANTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer_q <= '0;
    else if (grant)
      timer_q <= '0;
    else if (state_q == GRANTED && state_d == GRANTED)
      timer_q <= timer_q + TW'(1);
  end

endmodule
